credit_bank: RTL and testbench
==============================

Name: credit_bank

Overview:
- Parametrised successor of the main-screen credit block: NUM_CREDITS circular targets, each with its own digit counter.
- Adds per-credit hit lockout so one ball contact counts once, wrap or saturate counting, a post-hit flash, and a score-award output.
- Sits in the main screen between the pixel scanner and the object mux; collision input comes from the collision unit, award output goes to the score keeper.

Parameters:
- NUM_CREDITS, 4, number of credit targets (1..16); positions are defines::SCREEN_MAIN_CREDITS_TOP_LEFT_X/Y[0..NUM_CREDITS-1].
- INIT_VALUE, 0, counter value after reset and after reset_level_pulse (0..9).
- MAX_VALUE, 9, highest counter value (1..9).
- SATURATE, 0, 1 means hold at MAX_VALUE; 0 means wrap to 0.
- FLASH_FRAMES, 8, frames a credit flashes after a hit (0 disables, max 255).

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous reset, active-high (1 = reset)
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- collisionBallCredit  in  1  ball overlaps a credit pixel this cycle
- reset_level_pulse  in  1  synchronous level restart
- RGBCredit  out  8  pixel colour
- drawCredit  out  1  credit pixel present
- awardPulse  out  1  one-cycle pulse per counted hit
- awardValue  out  4  counter value of the hit credit before increment
- awardIndex  out  4  index of the hit credit

Behaviour:
- Geometry (combinational): circle i covers radius SCREEN_MAIN_CREDIT_RADIUS at its top-left. Digit square i is NUMBER_WIDTH x NUMBER_HEIGHT at top-left + SCREEN_MAIN_CREDIT_NUMBER_OFFSET_X/Y.
- hitIdx is the highest i whose circle is drawn this cycle; hitValid is set when any circle is drawn.
- Per-credit state: value[3:0], state ARMED/LOCKED, seen flag, flash counter [7:0].
- Hit: collisionBallCredit && hitValid && state[hitIdx]==ARMED. On a hit:
  - value advances by one; at MAX_VALUE it goes to 0 if SATURATE=0, else holds.
  - state goes to LOCKED, seen set, flash loaded with FLASH_FRAMES.
  - awardPulse=1 next cycle, with awardValue = old value and awardIndex = hitIdx.
- Collision while LOCKED: sets seen, no count, no award.
- Collision with hitValid=0: ignored.
- startOfFrame, per credit:
  - LOCKED and seen=0 goes to ARMED (one clean frame re-arms).
  - seen cleared.
  - flash decremented if nonzero.
  - A collision in the same cycle as startOfFrame is applied after the clear: seen=1 for the new frame, and a hit is counted if ARMED.
- reset_level_pulse: all values=INIT_VALUE, all ARMED, seen=0, flash=0, no award that cycle. It overrides a same-cycle collision and startOfFrame.
- resetN=1, at any time and mid-frame: same state as reset_level_pulse. Outputs go to drawCredit=0, RGBCredit=0, awardPulse=0, awardValue=0, awardIndex=0.
- Render (registered, 1-cycle latency from pixelX/Y):
  - drawCredit = circle hit OR digit glyph pixel.
  - Glyph pixel shows value[hitIdx] via number_bitmap, using the offset of square hitIdx.
  - RGBCredit = glyph colour on a glyph pixel, else COLOR_WHITE.
  - While flash[hitIdx] is nonzero and bit 1 of flash is 1, glyph and background colours swap (COLOR_WHITE on glyph, glyph colour on background).
- Widths: value 4-bit unsigned, never exceeds MAX_VALUE. Flash counter stops at 0.

Test Plan:
- Reset: resetN=1 for 3 cycles, then release -> all values=0, drawCredit=0 during reset, awardPulse=0.
- Single hit: hold collision on credit 2 for 40 cycles in one frame -> exactly one awardPulse (awardIndex=2, awardValue=0), value[2]=1.
- Re-arm: collide on credit 0 in frames 1 and 2, none in frame 3, collide in frame 4 -> two awards total, value[0]=2.
- Wrap vs saturate: 11 hits with clean frames between, MAX_VALUE=9. SATURATE=0 -> final value 1. SATURATE=1 -> final value 9 and 11 awards, last awardValue=9.
- Priority: reset_level_pulse, collision and startOfFrame in the same cycle with value[1]=5 -> value[1]=0, no award, state ARMED.
- Flash: FLASH_FRAMES=4 hit on credit 3 -> colours swapped in frames where flash bit1=1 (flash 3,2), normal from frame 4 on; drawCredit timing is 1 cycle after pixel.

Source files
------------

// File: rtl/credit_bank.sv
// credit_bank: NUM_CREDITS circular credit targets, each carrying a digit counter.
// A ball contact counts once per credit (hit lockout, re-armed by one clean frame),
// emits a one-cycle award to the score keeper and starts a post-hit flash.
// The render path is registered: outputs describe the pixel presented one cycle earlier.
module credit_bank #(
  parameter int unsigned NUM_CREDITS     = 4,
  parameter int unsigned INIT_VALUE      = 0,
  parameter int unsigned MAX_VALUE       = 9,
  parameter bit          SATURATE        = 1'b0,
  parameter int unsigned FLASH_FRAMES    = 8,
  // Screen placement: credit i has its top-left at (X0 + i*PITCH_X, Y0 + i*PITCH_Y).
  parameter int          CREDIT_X0       = 64,
  parameter int          CREDIT_Y0       = 48,
  parameter int          CREDIT_PITCH_X  = 96,
  parameter int          CREDIT_PITCH_Y  = 0,
  parameter int          CREDIT_RADIUS   = 16,
  parameter int          NUMBER_OFFSET_X = 12,
  parameter int          NUMBER_OFFSET_Y = 8,
  parameter int          NUMBER_WIDTH    = 8,
  parameter int          NUMBER_HEIGHT   = 16,
  parameter logic [7:0]  COLOR_WHITE     = 8'hFF,
  parameter logic [7:0]  COLOR_GLYPH     = 8'hE0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        collisionBallCredit,
  input  logic        reset_level_pulse,
  output logic [7:0]  RGBCredit,
  output logic        drawCredit,
  output logic        awardPulse,
  output logic [3:0]  awardValue,
  output logic [3:0]  awardIndex
);

  localparam logic [3:0] InitVal   = 4'(INIT_VALUE);
  localparam logic [3:0] MaxVal    = 4'(MAX_VALUE);
  localparam logic [7:0] FlashInit = 8'(FLASH_FRAMES);
  localparam int         RadiusSq  = CREDIT_RADIUS * CREDIT_RADIUS;

  // Per-credit state
  logic [3:0]             value_q [NUM_CREDITS];
  logic [3:0]             value_d [NUM_CREDITS];
  logic [7:0]             flash_q [NUM_CREDITS];
  logic [7:0]             flash_d [NUM_CREDITS];
  logic [NUM_CREDITS-1:0] locked_q, locked_d;
  logic [NUM_CREDITS-1:0] seen_q, seen_d;

  // Award register
  logic       award_q, award_d;
  logic [3:0] award_value_q, award_value_d;
  logic [3:0] award_index_q, award_index_d;

  // Geometry and render
  logic       hit_valid;
  logic [3:0] hit_idx;
  logic [3:0] sel_value;
  logic [7:0] sel_flash;
  logic       glyph_px;
  logic       flash_swap;
  logic       draw_d, draw_q;
  logic [7:0] rgb_d, rgb_q;

  // Segment set {g,f,e,d,c,b,a} for a decimal digit; blank for anything above 9.
  function automatic logic [6:0] seg_mask(input logic [3:0] digit);
    logic [6:0] m;
    case (digit)
      4'd0:    m = 7'h3F;
      4'd1:    m = 7'h06;
      4'd2:    m = 7'h5B;
      4'd3:    m = 7'h4F;
      4'd4:    m = 7'h66;
      4'd5:    m = 7'h6D;
      4'd6:    m = 7'h7D;
      4'd7:    m = 7'h07;
      4'd8:    m = 7'h7F;
      4'd9:    m = 7'h6F;
      default: m = 7'h00;
    endcase
    return m;
  endfunction

  // Seven-segment glyph lookup: segments are two pixels thick inside the digit square.
  function automatic logic seg_on(input logic [6:0] m, input int gx, input int gy);
    logic top, bot, mid, left, right, upper;
    top   = (gy <= 1);
    bot   = (gy >= NUMBER_HEIGHT - 2);
    mid   = (gy == NUMBER_HEIGHT / 2 - 1) || (gy == NUMBER_HEIGHT / 2);
    left  = (gx <= 1);
    right = (gx >= NUMBER_WIDTH - 2);
    upper = (gy < NUMBER_HEIGHT / 2);
    return (m[0] && top)            || (m[1] && right && upper) ||
           (m[2] && right && !upper) || (m[3] && bot)            ||
           (m[4] && left && !upper)  || (m[5] && left && upper)  ||
           (m[6] && mid);
  endfunction

  // Circle membership: the highest-numbered credit containing the pixel wins.
  always_comb begin
    int dx, dy;
    dx        = 0;
    dy        = 0;
    hit_valid = 1'b0;
    hit_idx   = 4'd0;
    for (int i = 0; i < int'(NUM_CREDITS); i++) begin
      dx = int'(pixelX) - (CREDIT_X0 + i * CREDIT_PITCH_X + CREDIT_RADIUS);
      dy = int'(pixelY) - (CREDIT_Y0 + i * CREDIT_PITCH_Y + CREDIT_RADIUS);
      if (dx * dx + dy * dy <= RadiusSq) begin
        hit_valid = 1'b1;
        hit_idx   = 4'(i);
      end
    end
  end

  // Digit glyph of the selected credit and its flash state.
  always_comb begin
    int  gx, gy;
    logic in_sq;
    sel_value = '0;
    sel_flash = '0;
    for (int i = 0; i < int'(NUM_CREDITS); i++) begin
      if (hit_idx == 4'(i)) begin
        sel_value = value_q[i];
        sel_flash = flash_q[i];
      end
    end
    gx = int'(pixelX) - (CREDIT_X0 + int'(hit_idx) * CREDIT_PITCH_X + NUMBER_OFFSET_X);
    gy = int'(pixelY) - (CREDIT_Y0 + int'(hit_idx) * CREDIT_PITCH_Y + NUMBER_OFFSET_Y);
    in_sq      = (gx >= 0) && (gx < NUMBER_WIDTH) && (gy >= 0) && (gy < NUMBER_HEIGHT);
    glyph_px   = in_sq && seg_on(seg_mask(sel_value), gx, gy);
    flash_swap = (sel_flash != '0) && sel_flash[1];
  end

  // Pixel colour; non-credit pixels are driven to zero so the mux sees a clean bus.
  always_comb begin
    draw_d = hit_valid || glyph_px;
    rgb_d  = 8'h00;
    if (draw_d) begin
      if (glyph_px) begin
        rgb_d = flash_swap ? COLOR_WHITE : COLOR_GLYPH;
      end else begin
        rgb_d = flash_swap ? COLOR_GLYPH : COLOR_WHITE;
      end
    end
  end

  // Next-state: frame boundary housekeeping first, then the collision of this cycle,
  // with a level restart overriding both.
  always_comb begin
    value_d       = value_q;
    flash_d       = flash_q;
    locked_d      = locked_q;
    seen_d        = seen_q;
    award_d       = 1'b0;
    award_value_d = award_value_q;
    award_index_d = award_index_q;

    for (int i = 0; i < int'(NUM_CREDITS); i++) begin
      if (startOfFrame) begin
        // A locked credit untouched for a whole frame becomes armed again.
        if (locked_q[i] && !seen_q[i]) begin
          locked_d[i] = 1'b0;
        end
        seen_d[i] = 1'b0;
        if (flash_q[i] != 8'd0) begin
          flash_d[i] = flash_q[i] - 8'd1;
        end
      end

      if (collisionBallCredit && hit_valid && (hit_idx == 4'(i))) begin
        seen_d[i] = 1'b1;
        if (!locked_d[i]) begin
          locked_d[i] = 1'b1;
          flash_d[i]  = FlashInit;
          if (value_q[i] >= MaxVal) begin
            value_d[i] = SATURATE ? MaxVal : 4'd0;
          end else begin
            value_d[i] = value_q[i] + 4'd1;
          end
          award_d       = 1'b1;
          award_value_d = value_q[i];
          award_index_d = hit_idx;
        end
      end
    end

    if (reset_level_pulse) begin
      for (int i = 0; i < int'(NUM_CREDITS); i++) begin
        value_d[i]  = InitVal;
        flash_d[i]  = 8'd0;
        locked_d[i] = 1'b0;
        seen_d[i]   = 1'b0;
      end
      award_d = 1'b0;
    end
  end

  // Per-credit state registers.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      for (int i = 0; i < int'(NUM_CREDITS); i++) begin
        value_q[i] <= InitVal;
        flash_q[i] <= 8'd0;
      end
      locked_q <= '0;
      seen_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CREDITS); i++) begin
        value_q[i] <= value_d[i];
        flash_q[i] <= flash_d[i];
      end
      locked_q <= locked_d;
      seen_q   <= seen_d;
    end
  end

  // Award and render output registers.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      award_q       <= 1'b0;
      award_value_q <= 4'd0;
      award_index_q <= 4'd0;
      draw_q        <= 1'b0;
      rgb_q         <= 8'h00;
    end else begin
      award_q       <= award_d;
      award_value_q <= award_value_d;
      award_index_q <= award_index_d;
      draw_q        <= draw_d;
      rgb_q         <= rgb_d;
    end
  end

  assign awardPulse = award_q;
  assign awardValue = award_value_q;
  assign awardIndex = award_index_q;
  assign drawCredit = draw_q;
  assign RGBCredit  = rgb_q;

endmodule

// File: tb/tb_credit_bank.sv
// Bench for credit_bank: a wrapping and a saturating instance share the stimulus.
// Awards are predicted into per-instance queues and popped as the DUTs emit them;
// render behaviour is checked from a vector table and a flash sequence.
module tb_credit_bank;

  localparam int X0 = 64, Y0 = 48, PX = 96, R = 16, OX = 12, OY = 8;
  localparam logic [7:0] WHITE = 8'hFF, GLYPH = 8'hE0;
  // Probe kinds: circle background, top segment, middle segment, upper-right segment, off.
  localparam int PBG = 0, PTOP = 1, PMID = 2, PRIGHT = 3, PNONE = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, collisionBallCredit, reset_level_pulse;

  logic [7:0]  rgb_w, rgb_s;
  logic        draw_w, draw_s, award_w, award_s;
  logic [3:0]  aval_w, aval_s, aidx_w, aidx_s;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_wrap[$];
  logic [7:0] q_sat[$];
  logic [7:0] e_w, e_s;

  typedef struct {
    int         cred;
    int         kind;
    logic       exp_draw;
    logic [7:0] exp_rgb;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  credit_bank #(
    .NUM_CREDITS(4), .INIT_VALUE(0), .MAX_VALUE(9), .SATURATE(1'b0), .FLASH_FRAMES(4),
    .CREDIT_X0(X0), .CREDIT_Y0(Y0), .CREDIT_PITCH_X(PX), .CREDIT_PITCH_Y(0),
    .CREDIT_RADIUS(R), .NUMBER_OFFSET_X(OX), .NUMBER_OFFSET_Y(OY),
    .NUMBER_WIDTH(8), .NUMBER_HEIGHT(16), .COLOR_WHITE(WHITE), .COLOR_GLYPH(GLYPH)
  ) dut_wrap (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .collisionBallCredit(collisionBallCredit),
    .reset_level_pulse(reset_level_pulse), .RGBCredit(rgb_w), .drawCredit(draw_w),
    .awardPulse(award_w), .awardValue(aval_w), .awardIndex(aidx_w)
  );

  credit_bank #(
    .NUM_CREDITS(4), .INIT_VALUE(0), .MAX_VALUE(9), .SATURATE(1'b1), .FLASH_FRAMES(4),
    .CREDIT_X0(X0), .CREDIT_Y0(Y0), .CREDIT_PITCH_X(PX), .CREDIT_PITCH_Y(0),
    .CREDIT_RADIUS(R), .NUMBER_OFFSET_X(OX), .NUMBER_OFFSET_Y(OY),
    .NUMBER_WIDTH(8), .NUMBER_HEIGHT(16), .COLOR_WHITE(WHITE), .COLOR_GLYPH(GLYPH)
  ) dut_sat (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .collisionBallCredit(collisionBallCredit),
    .reset_level_pulse(reset_level_pulse), .RGBCredit(rgb_s), .drawCredit(draw_s),
    .awardPulse(award_s), .awardValue(aval_s), .awardIndex(aidx_s)
  );

  function automatic logic [10:0] px_of(input int cred, input int kind);
    int base;
    base = X0 + cred * PX;
    case (kind)
      PBG:     return 11'(base + R);
      PTOP:    return 11'(base + OX + 3);
      PMID:    return 11'(base + OX + 3);
      PRIGHT:  return 11'(base + OX + 6);
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] py_of(input int kind);
    case (kind)
      PBG:     return 11'(Y0 + 2);
      PTOP:    return 11'(Y0 + OY);
      PMID:    return 11'(Y0 + OY + 7);
      PRIGHT:  return 11'(Y0 + OY + 4);
      default: return 11'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns just after the edge that consumed them.
  task automatic step(input logic [10:0] x, input logic [10:0] y,
                      input logic sof, input logic coll, input logic lvl);
    @(negedge clk);
    pixelX              = x;
    pixelY              = y;
    startOfFrame        = sof;
    collisionBallCredit = coll;
    reset_level_pulse   = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic level_restart();
    step(11'd0, 11'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic hit(input int cred, input int n);
    repeat (n) step(11'(X0 + cred * PX + R), 11'(Y0 + R), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_award(input int idx, input int v_wrap, input int v_sat);
    q_wrap.push_back({4'(idx), 4'(v_wrap)});
    q_sat.push_back({4'(idx), 4'(v_sat)});
  endtask

  // Let pending awards surface, then require every predicted award to have appeared.
  task automatic drain(input string name);
    repeat (3) step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    chk($sformatf("%s pending wrap awards", name), q_wrap.size(), 0);
    chk($sformatf("%s pending sat awards", name), q_sat.size(), 0);
  endtask

  task automatic probe(input string name, input int cred, input int kind,
                       input logic exp_draw, input logic [7:0] exp_rgb);
    step(px_of(cred, kind), py_of(kind), 1'b0, 1'b0, 1'b0);
    chk($sformatf("%s draw", name), draw_w, exp_draw);
    if (exp_draw) chk($sformatf("%s rgb", name), rgb_w, exp_rgb);
  endtask

  // Award scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (award_w === 1'b1) begin
      n_vec++;
      if (q_wrap.size() == 0) begin
        n_err++;
        $display("FAIL award_wrap: got idx %0d val %0d, required none", aidx_w, aval_w);
      end else begin
        e_w = q_wrap.pop_front();
        if ({aidx_w, aval_w} !== e_w) begin
          n_err++;
          $display("FAIL award_wrap: got idx %0d val %0d, required idx %0d val %0d",
                   aidx_w, aval_w, e_w[7:4], e_w[3:0]);
        end
      end
    end
    if (award_s === 1'b1) begin
      n_vec++;
      if (q_sat.size() == 0) begin
        n_err++;
        $display("FAIL award_sat: got idx %0d val %0d, required none", aidx_s, aval_s);
      end else begin
        e_s = q_sat.pop_front();
        if ({aidx_s, aval_s} !== e_s) begin
          n_err++;
          $display("FAIL award_sat: got idx %0d val %0d, required idx %0d val %0d",
                   aidx_s, aval_s, e_s[7:4], e_s[3:0]);
        end
      end
    end
  end

  initial begin
    logic sw;
    tbl[0] = '{cred: 0, kind: PBG,    exp_draw: 1'b1, exp_rgb: WHITE};
    tbl[1] = '{cred: 0, kind: PTOP,   exp_draw: 1'b1, exp_rgb: GLYPH};
    tbl[2] = '{cred: 0, kind: PMID,   exp_draw: 1'b1, exp_rgb: WHITE};
    tbl[3] = '{cred: 0, kind: PNONE,  exp_draw: 1'b0, exp_rgb: 8'h00};
    tbl[4] = '{cred: 3, kind: PTOP,   exp_draw: 1'b1, exp_rgb: GLYPH};
    tbl[5] = '{cred: 2, kind: PMID,   exp_draw: 1'b1, exp_rgb: WHITE};
    tbl[6] = '{cred: 1, kind: PRIGHT, exp_draw: 1'b1, exp_rgb: GLYPH};

    resetN              = 1'b1;
    pixelX              = px_of(0, PBG);
    pixelY              = py_of(PBG);
    startOfFrame        = 1'b0;
    collisionBallCredit = 1'b0;
    reset_level_pulse   = 1'b0;

    // Reset held for three cycles with a credit pixel on the scanner.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("reset draw_wrap", draw_w, 1'b0);
      chk("reset rgb_wrap", rgb_w, 8'h00);
      chk("reset award_wrap", {award_w, aidx_w, aval_w}, 9'h000);
      chk("reset draw_sat", draw_s, 1'b0);
    end
    @(negedge clk);
    resetN = 1'b0;

    // Render table in reset state: all digits 0, no flash.
    for (int v = 0; v < 7; v++) begin
      probe($sformatf("render[%0d]", v), tbl[v].cred, tbl[v].kind, tbl[v].exp_draw,
            tbl[v].exp_rgb);
    end

    // Collision with no credit pixel is ignored.
    repeat (4) step(11'd0, 11'd0, 1'b0, 1'b1, 1'b0);
    drain("no-circle collision");

    // Single held contact counts once.
    expect_award(2, 0, 0);
    hit(2, 40);
    drain("single hit");
    probe("credit2 value1 top", 2, PTOP, 1'b1, WHITE);
    probe("credit2 value1 right", 2, PRIGHT, 1'b1, GLYPH);

    // Re-arm only after a clean frame.
    frame();
    expect_award(0, 0, 0);
    hit(0, 5);
    frame();
    hit(0, 5);
    frame();
    frame();
    expect_award(0, 1, 1);
    hit(0, 5);
    drain("re-arm");
    probe("credit0 value2 mid", 0, PMID, 1'b1, GLYPH);

    // Bring credit 1 to 5, then level restart beats collision and frame start.
    for (int k = 0; k < 5; k++) begin
      frame();
      frame();
      expect_award(1, k, k);
      hit(1, 3);
    end
    drain("count to 5");
    frame();
    frame();
    step(px_of(1, PBG), 11'(Y0 + R), 1'b1, 1'b1, 1'b1);
    drain("priority no award");
    expect_award(1, 0, 0);
    hit(1, 3);
    drain("priority armed at 0");

    // Frame start and collision together: re-arm happens first, hit counts.
    frame();
    expect_award(1, 1, 1);
    step(px_of(1, PBG), 11'(Y0 + R), 1'b1, 1'b1, 1'b0);
    hit(1, 3);
    drain("sof with collision");

    // Wrap versus saturate over 11 hits, then one more to expose the final value.
    level_restart();
    for (int k = 0; k < 11; k++) begin
      frame();
      frame();
      expect_award(1, (k > 9) ? 0 : k, (k > 9) ? 9 : k);
      hit(1, 3);
    end
    frame();
    frame();
    expect_award(1, 1, 9);
    hit(1, 3);
    drain("wrap/saturate");

    // Flash: loaded with 4, swapped while the counter reads 3 and 2.
    level_restart();
    expect_award(3, 0, 0);
    hit(3, 2);
    drain("flash hit");
    for (int f = 0; f < 6; f++) begin
      if (f > 0) frame();
      sw = (f == 1) || (f == 2);
      probe($sformatf("flash f%0d bg", f), 3, PBG, 1'b1, sw ? GLYPH : WHITE);
      probe($sformatf("flash f%0d glyph", f), 3, PRIGHT, 1'b1, sw ? WHITE : GLYPH);
    end

    // Asynchronous reset mid-run clears counters and lockout.
    frame();
    frame();
    expect_award(0, 0, 0);
    hit(0, 2);
    drain("pre-reset hit");
    @(negedge clk);
    pixelX = px_of(0, PBG);
    pixelY = py_of(PBG);
    resetN = 1'b1;
    #1;
    chk("mid reset draw", draw_w, 1'b0);
    chk("mid reset award", {award_w, aidx_w, aval_w}, 9'h000);
    @(negedge clk);
    resetN = 1'b0;
    expect_award(0, 0, 0);
    hit(0, 2);
    drain("post-reset hit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
